// File: rtl/square_wave_detector.sv
// Square-wave tone detector: measures the period of wave_inP, locks onto an in-tolerance tone, flags loss of signal.
// Optional leg-mismatch check on wave_inN is compiled in with SQUARE_WAVE_DIFF_CHECK_EN.
module square_wave_detector #(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned WAVE_FREQ  = 1_000,
    parameter int unsigned EXP_PERIOD = CLK_FREQ / WAVE_FREQ,
    parameter int unsigned TOL        = 250,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 2 * EXP_PERIOD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wave_inP,
    input  logic        wave_inN,
    output logic [31:0] period_out,
    output logic        period_valid,
    output logic        locked,
    output logic        no_signal,
    output logic        diff_err,
    output logic        led
);

    localparam logic [31:0] PERIOD_MIN = 32'(EXP_PERIOD - TOL);
    localparam logic [31:0] PERIOD_MAX = 32'(EXP_PERIOD + TOL);
    localparam logic [31:0] COUNT_LAST = 32'(TIMEOUT - 1);
    localparam int unsigned GW         = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   counter, counter_nxt;
    logic [GW-1:0] good_cnt, good_nxt;
    logic [31:0]   period_nxt;
    logic          valid_nxt;
    logic [31:0]   period_meas;
    logic          in_tol;

    logic p_meta, p_sync, p_hist;
    logic rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_meta <= 1'b0;
            p_sync <= 1'b0;
            p_hist <= 1'b0;
        end else begin
            p_meta <= wave_inP;
            p_sync <= p_meta;
            p_hist <= p_sync;
        end
    end

    assign rise = p_sync & ~p_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= '0;
            good_cnt     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            counter      <= counter_nxt;
            good_cnt     <= good_nxt;
            period_out   <= period_nxt;
            period_valid <= valid_nxt;
        end
    end

    // The edge that closes a period counts itself, hence counter + 1.
    assign period_meas = counter + 32'd1;
    assign in_tol      = (period_meas >= PERIOD_MIN) && (period_meas <= PERIOD_MAX);

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        good_nxt    = good_cnt;
        period_nxt  = period_out;
        valid_nxt   = 1'b0;
        case (state)
            IDLE: begin
                counter_nxt = '0;
                good_nxt    = '0;
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (rise) begin
                    counter_nxt = '0;
                    period_nxt  = period_meas;
                    valid_nxt   = 1'b1;
                    if (!in_tol) begin
                        good_nxt  = '0;
                        state_nxt = MEASURE;
                    end else if (state == MEASURE) begin
                        good_nxt = good_cnt + GW'(1);
                        if (good_cnt + GW'(1) == GOOD_TARGET) begin
                            state_nxt = LOCKED;
                        end
                    end
                end else if (counter == COUNT_LAST) begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                    good_nxt    = '0;
                end else begin
                    counter_nxt = counter + 32'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
                good_nxt    = '0;
            end
        endcase
    end

    assign locked    = (state == LOCKED);
    assign led       = locked;
    assign no_signal = (state == IDLE);

`ifdef SQUARE_WAVE_DIFF_CHECK_EN
    logic       n_meta, n_sync;
    logic [2:0] eq_run;
    logic       diff_flag;

    // Error sets on the fifth consecutive cycle of equal synced legs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_meta    <= 1'b0;
            n_sync    <= 1'b0;
            eq_run    <= '0;
            diff_flag <= 1'b0;
        end else begin
            n_meta <= wave_inN;
            n_sync <= n_meta;
            if (p_sync == n_sync) begin
                if (eq_run < 3'd4) begin
                    eq_run <= eq_run + 3'd1;
                end else begin
                    diff_flag <= 1'b1;
                end
            end else begin
                eq_run <= '0;
            end
        end
    end

    assign diff_err = diff_flag;
`else
    logic unused_wave_n;
    assign unused_wave_n = wave_inN;
    assign diff_err      = 1'b0;
`endif

endmodule
